// File: rtl/lsu_pkg.sv
// Shared constants, lane layout and state encoding for the LSU instruction sequencer.
// A context entry packs four lanes, lsu1 in the least significant INST_W bits.
package lsu_pkg;

   localparam int INST_W    = 18;
   localparam int NUM_LANES = 4;
   localparam int ENTRY_W   = NUM_LANES * INST_W;

   localparam logic [INST_W-1:0] NOP = 18'h0;

   localparam int LANE1_LSB = 0;
   localparam int LANE2_LSB = INST_W;
   localparam int LANE3_LSB = 2 * INST_W;
   localparam int LANE4_LSB = 3 * INST_W;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } lsu_state_e;

   // Lane offset for an arbitrary instruction width; lane 0 is lsu1.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/lsu_ctx_mem.sv
// Context register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a configured program survives rst.
module lsu_ctx_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 72,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lsu_inst_sequencer.sv
// Steps through context entries 0..last_pc for iter_count iterations, issuing one
// registered entry per cycle to the four LSUs, with stall hold and a done pulse.
module lsu_inst_sequencer
   import lsu_pkg::lsu_state_e, lsu_pkg::IDLE, lsu_pkg::RUN, lsu_pkg::lane_lsb;
#(
   parameter int CTX_DEPTH = 16,
   parameter int INST_W    = 18,
   parameter int ITER_W    = 16,
   localparam int PC_W     = $clog2(CTX_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [PC_W-1:0]     cfg_addr,
   input  logic [4*INST_W-1:0] cfg_data,
   input  logic                start,
   input  logic [PC_W-1:0]     last_pc,
   input  logic [ITER_W-1:0]   iter_count,
   input  logic                stall,
   output logic [INST_W-1:0]   lsu1_inst,
   output logic [INST_W-1:0]   lsu2_inst,
   output logic [INST_W-1:0]   lsu3_inst,
   output logic [INST_W-1:0]   lsu4_inst,
   output logic                inst_valid,
   output logic                busy,
   output logic                done,
   output logic [PC_W-1:0]     cur_pc,
   output logic [ITER_W-1:0]   cur_iter
);

   localparam int ENTRY_W = 4 * INST_W;

   // Issue semantics: while inst_valid=1 the lanes, cur_pc and cur_iter describe one
   // live entry; the entry advances at a clock edge only if stall=0 at that edge.
   // busy mirrors the FSM state (1 = RUN) and serves as its observable debug view.
   lsu_state_e           state;
   logic [ENTRY_W-1:0]   entry_q;
   logic [ENTRY_W-1:0]   rd_data;
   logic [ENTRY_W-1:0]   first_entry;
   logic [PC_W-1:0]      pc_q;
   logic [PC_W-1:0]      last_pc_q;
   logic [PC_W-1:0]      rd_addr;
   logic [ITER_W-1:0]    iter_q;
   logic [ITER_W-1:0]    iter_cnt_q;
   logic                 valid_q;
   logic                 done_q;
   logic                 mem_we;
   logic                 at_last_pc;
   logic                 at_last_iter;

   assign mem_we       = cfg_we && !rst && (state == IDLE);
   assign at_last_pc   = (pc_q == last_pc_q);
   assign at_last_iter = (iter_q == iter_cnt_q - ITER_W'(1));

   lsu_ctx_mem #(
      .DEPTH (CTX_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ctx_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // In IDLE the read port points at entry 0 so a start can load it directly.
   always_comb begin
      rd_addr = '0;
      if (state == RUN && !at_last_pc) begin
         rd_addr = pc_q + PC_W'(1);
      end
   end

   // A write to entry 0 in the start cycle must be visible in the first issue.
   assign first_entry = (cfg_we && cfg_addr == '0) ? cfg_data : rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         entry_q    <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         pc_q       <= '0;
         iter_q     <= '0;
         last_pc_q  <= '0;
         iter_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               last_pc_q  <= last_pc;
               iter_cnt_q <= iter_count;
               if (iter_count != '0) begin
                  state   <= RUN;
                  entry_q <= first_entry;
                  valid_q <= 1'b1;
                  pc_q    <= '0;
                  iter_q  <= '0;
               end else begin
                  done_q <= 1'b1;
               end
            end
         end else if (!stall) begin
            if (!at_last_pc) begin
               pc_q    <= pc_q + PC_W'(1);
               entry_q <= rd_data;
            end else if (!at_last_iter) begin
               pc_q    <= '0;
               iter_q  <= iter_q + ITER_W'(1);
               entry_q <= rd_data;
            end else begin
               state   <= IDLE;
               entry_q <= '0;
               valid_q <= 1'b0;
               pc_q    <= '0;
               iter_q  <= '0;
               done_q  <= 1'b1;
            end
         end
      end
   end

   assign lsu1_inst  = entry_q[lane_lsb(0, INST_W) +: INST_W];
   assign lsu2_inst  = entry_q[lane_lsb(1, INST_W) +: INST_W];
   assign lsu3_inst  = entry_q[lane_lsb(2, INST_W) +: INST_W];
   assign lsu4_inst  = entry_q[lane_lsb(3, INST_W) +: INST_W];
   assign inst_valid = valid_q;
   assign busy       = (state == RUN);
   assign done       = done_q;
   assign cur_pc     = pc_q;
   assign cur_iter   = iter_q;

endmodule

// File: tb/tb_lsu_inst_sequencer.sv
// Randomised scoreboard bench for lsu_inst_sequencer: a queue-based program model
// predicts every issued entry and done pulse; a negedge monitor pops and compares.
module tb_lsu_inst_sequencer;

   localparam int PC_W    = 4;
   localparam int ITER_W  = 16;
   localparam int INST_W  = 18;
   localparam int ENTRY_W = 4 * INST_W;
   localparam int REC_W   = 3 + PC_W + ITER_W + ENTRY_W;

   // clock / reset and DUT signals
   logic                clk = 1'b0;
   logic                rst;
   logic                cfg_we;
   logic [PC_W-1:0]     cfg_addr;
   logic [ENTRY_W-1:0]  cfg_data;
   logic                start;
   logic [PC_W-1:0]     last_pc;
   logic [ITER_W-1:0]   iter_count;
   logic                stall;
   logic [INST_W-1:0]   lsu1_inst, lsu2_inst, lsu3_inst, lsu4_inst;
   logic                inst_valid, busy, done;
   logic [PC_W-1:0]     cur_pc;
   logic [ITER_W-1:0]   cur_iter;

   always #5 clk = ~clk;

   lsu_inst_sequencer #(
      .CTX_DEPTH  (16),
      .INST_W     (INST_W),
      .ITER_W     (ITER_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .start      (start),
      .last_pc    (last_pc),
      .iter_count (iter_count),
      .stall      (stall),
      .lsu1_inst  (lsu1_inst),
      .lsu2_inst  (lsu2_inst),
      .lsu3_inst  (lsu3_inst),
      .lsu4_inst  (lsu4_inst),
      .inst_valid (inst_valid),
      .busy       (busy),
      .done       (done),
      .cur_pc     (cur_pc),
      .cur_iter   (cur_iter)
   );

   // scoreboard state
   logic [REC_W-1:0]   exp_q[$];
   logic [ENTRY_W-1:0] ctx_ref [16];
   bit                 stall_plan[$];
   int                 run_cycles;
   int                 checks = 0;
   int                 errors = 0;
   bit                 mon_en = 1'b0;

   function automatic logic [REC_W-1:0] mk(input bit b, input bit v, input bit d,
                                           input logic [PC_W-1:0] pc,
                                           input logic [ITER_W-1:0] it,
                                           input logic [ENTRY_W-1:0] e);
      return {b, v, d, pc, it, e};
   endfunction

   function automatic logic [ENTRY_W-1:0] rand_entry();
      logic [ENTRY_W-1:0] e;
      for (int l = 0; l < 4; l++) begin
         e[l*INST_W +: INST_W] = INST_W'($urandom_range(0, 262143));
      end
      return e;
   endfunction

   // Program model: the run issues entries idx = 0..(last+1)*iters-1, entry idx%(last+1)
   // in iteration idx/(last+1); a stalled cycle shows the same idx again.
   task automatic predict(input logic [PC_W-1:0] lp, input logic [ITER_W-1:0] ic,
                          input int pct, input int stop_at);
      int total;
      int idx;
      int cyc;
      logic [PC_W-1:0]   pcv;
      logic [ITER_W-1:0] itv;
      total = (int'(lp) + 1) * int'(ic);
      idx = 0;
      cyc = 0;
      while (idx < total && (stop_at < 0 || cyc < stop_at)) begin
         if (cyc >= stall_plan.size()) stall_plan.push_back($urandom_range(0, 99) < pct);
         pcv = PC_W'(idx % (int'(lp) + 1));
         itv = ITER_W'(idx / (int'(lp) + 1));
         exp_q.push_back(mk(1'b1, 1'b1, 1'b0, pcv, itv, ctx_ref[pcv]));
         if (!stall_plan[cyc]) idx++;
         cyc++;
      end
      run_cycles = cyc;
      if (idx == total) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, '0, '0, '0));
   endtask

   // driver tasks
   task automatic write_ctx(input logic [PC_W-1:0] a, input logic [ENTRY_W-1:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      ctx_ref[a] = d;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(1, 3)) begin
         stall = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      stall = 1'b0;
   endtask

   task automatic launch(input logic [PC_W-1:0] lp, input logic [ITER_W-1:0] ic,
                         input int pct, input bit noise, input int stop_at,
                         input bit wr0, input logic [ENTRY_W-1:0] wr0_data);
      if (wr0) ctx_ref[0] = wr0_data;
      predict(lp, ic, pct, stop_at);
      start = 1'b1;
      last_pc = lp;
      iter_count = ic;
      cfg_we = wr0;
      cfg_addr = '0;
      cfg_data = wr0_data;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_we = 1'b0;
      for (int c = 0; c < run_cycles; c++) begin
         stall = stall_plan[c];
         last_pc = PC_W'($urandom_range(0, 15));
         iter_count = ITER_W'($urandom_range(0, 65535));
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            cfg_we = 1'($urandom_range(0, 1));
            cfg_addr = PC_W'($urandom_range(0, 15));
            cfg_data = rand_entry();
            if (c == 0) begin
               cfg_we = 1'b1;
               cfg_addr = PC_W'(1);
               cfg_data = '1;
            end
         end
         if (stop_at >= 0 && c == run_cycles - 1) rst = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      cfg_we = 1'b0;
      rst = 1'b0;
      stall = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      stall = 1'b0;
      stall_plan.delete();
      wait_drain();
      idle_gap();
   endtask

   task automatic set_plan(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) stall_plan.push_back(bits[i]);
   endtask

   // monitor: pops one record per live entry or done pulse, otherwise expects quiet outputs
   always @(negedge clk) begin
      logic [REC_W-1:0] act;
      logic [REC_W-1:0] exp_w;
      if (mon_en) begin
         act = {busy, inst_valid, done, cur_pc, cur_iter,
                lsu4_inst, lsu3_inst, lsu2_inst, lsu1_inst};
         checks++;
         if (inst_valid || done) begin
            if (!inst_valid) act[ENTRY_W +: PC_W + ITER_W] = '0;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got %h, required no output", act);
            end else begin
               exp_w = exp_q.pop_front();
               if (act !== exp_w) begin
                  errors++;
                  $display("FAIL %s: got %h, required %h",
                           exp_w[REC_W-3] ? "done" : "issue", act, exp_w);
               end
            end
         end else if ({busy, lsu4_inst, lsu3_inst, lsu2_inst, lsu1_inst} !== '0) begin
            errors++;
            $display("FAIL idle_zero: got busy=%b lanes=%h, required all 0", busy,
                     {lsu4_inst, lsu3_inst, lsu2_inst, lsu1_inst});
         end
      end
   end

   initial begin
      logic [ENTRY_W-1:0] e;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
      start = 1'b0;
      last_pc = '0;
      iter_count = '0;
      stall = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         start = 1'($urandom_range(0, 1));
         stall = 1'($urandom_range(0, 1));
         last_pc = PC_W'($urandom_range(0, 15));
         iter_count = ITER_W'($urandom_range(0, 65535));
         cfg_addr = PC_W'($urandom_range(0, 15));
         cfg_data = rand_entry();
         @(posedge clk); #1;
         mon_en = 1'b1;
      end
      rst = 1'b0;
      start = 1'b0;
      stall = 1'b0;
      checks++;
      if ({busy, inst_valid, done, cur_pc, cur_iter, lsu4_inst, lsu3_inst, lsu2_inst,
           lsu1_inst} !== mk(1'b0, 1'b0, 1'b0, '0, '0, '0)) begin
         errors++;
         $display("FAIL reset_state: got valid=%b busy=%b done=%b pc=%0d iter=%0d, required all 0",
                  inst_valid, busy, done, cur_pc, cur_iter);
      end

      // single entry read back after reset
      write_ctx(0, rand_entry());
      launch(0, 1, 0, 1'b0, -1, 1'b0, '0);

      // basic three-entry, two-iteration program
      for (int i = 0; i < 3; i++) begin
         e = {INST_W'(18'h44 + i), INST_W'(18'h33 + i), INST_W'(18'h22 + i), INST_W'(18'h11 + i)};
         write_ctx(PC_W'(i), e);
      end
      launch(2, 2, 0, 1'b0, -1, 1'b0, '0);

      // stall on entry 1 of iteration 0, then on the final entry
      set_plan(16'b0000_0000_0000_0110, 8);
      launch(2, 2, 0, 1'b0, -1, 1'b0, '0);
      set_plan(16'b0000_0000_1110_0000, 9);
      launch(2, 2, 0, 1'b0, -1, 1'b0, '0);

      // zero iterations
      launch(5, 0, 0, 1'b0, -1, 1'b0, '0);

      // start and cfg_we during RUN are ignored; next run still sees old ctx[1]
      launch(2, 2, 0, 1'b1, -1, 1'b0, '0);
      launch(1, 1, 0, 1'b0, -1, 1'b0, '0);

      // write to entry 0 in the same cycle as start
      launch(1, 2, 0, 1'b0, -1, 1'b1, rand_entry());

      // mid-run reset while entry 1 is live, then restart on entry 0 only
      launch(2, 2, 0, 1'b0, 2, 1'b0, '0);
      launch(0, 3, 0, 1'b0, -1, 1'b0, '0);

      // maximum iteration count, cut short by reset
      launch(1, 16'hFFFF, 20, 1'b1, 7, 1'b0, '0);

      // randomised programs
      for (int r = 0; r < 14; r++) begin
         repeat ($urandom_range(0, 4)) write_ctx(PC_W'($urandom_range(0, 15)), rand_entry());
         launch(PC_W'($urandom_range(0, 15)), ITER_W'($urandom_range(0, 3)),
                $urandom_range(0, 40), 1'($urandom_range(0, 1)), -1,
                1'($urandom_range(0, 1)), rand_entry());
      end

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_inst_sequencer.md
Name: lsu_inst_sequencer

Overview:
- Context-driven controller that sequences the four LSUs of the datapath.
- Holds a small context memory; each entry packs one 18-bit instruction per LSU.
- On a start pulse, steps through entries 0..last_pc once per iteration, for iter_count iterations, driving lsu1_inst..lsu4_inst each cycle.
- Supports a stall input and a one-cycle done pulse. Sits between the configuration/host interface and the datapath inst_in ports.

Parameters:
- CTX_DEPTH, 16, number of context entries (power of two, >=2)
- INST_W, 18, per-LSU instruction width
- ITER_W, 16, width of the iteration counter
- PC_W (localparam), $clog2(CTX_DEPTH), context address width

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cfg_we  input  1  context write strobe
- cfg_addr  input  PC_W  context write address
- cfg_data  input  4*INST_W  entry: [17:0]=lsu1, [35:18]=lsu2, [53:36]=lsu3, [71:54]=lsu4
- start  input  1  launch request, sampled in IDLE only
- last_pc  input  PC_W  final entry index per iteration, latched at start
- iter_count  input  ITER_W  number of iterations, latched at start
- stall  input  1  freeze issue while high
- lsu1_inst..lsu4_inst  output  INST_W each  registered instructions to LSUs
- inst_valid  output  1  outputs carry a live context entry
- busy  output  1  sequencer in RUN
- done  output  1  single-cycle completion pulse
- cur_pc  output  PC_W  index of entry currently on outputs
- cur_iter  output  ITER_W  zero-based iteration of current entry

Behaviour:
- The clock port is clk; reset is rst, synchronous and active-high. No other clocks.
- Instruction value 0 is NOP. On reset and whenever inst_valid=0, all lsuN_inst outputs are 0.
- Reset values: all instruction outputs 0; inst_valid, busy and done 0; cur_pc and cur_iter 0; state IDLE.
- Context memory is a register array and is not cleared by rst. Its contents survive reset.
- States: IDLE, RUN.
- cfg_we:
  - In IDLE: writes cfg_data to ctx[cfg_addr] at the clock edge.
  - In RUN: ignored, contents unchanged.
- start in IDLE with iter_count!=0:
  - Latch last_pc and iter_count.
  - Next cycle: state RUN, outputs = ctx[0], inst_valid=1, busy=1, cur_pc=0, cur_iter=0. Latency from start to first instruction is one cycle.
- start in IDLE with iter_count==0:
  - Stay IDLE, issue nothing.
  - done=1 for exactly the next cycle.
- start during RUN: ignored.
- RUN, stall=0, each cycle advance:
  - If cur_pc!=last_pc: pc+1.
  - Else if cur_iter!=iter_count-1: pc=0, iter+1.
  - Else (final entry): go to IDLE. Next cycle has inst_valid=0, busy=0, outputs 0, done=1 (one cycle only).
- RUN, stall=1: all outputs, cur_pc and cur_iter hold. This includes the final entry, which is held until stall drops.
- stall in IDLE: no effect. done is never extended by stall.
- Issue count without stalls is (last_pc+1)*iter_count cycles, then done.
- last_pc=0 is legal: entry 0 repeats iter_count times.
- A cfg_we and a start in the same IDLE cycle: the write takes effect, and the first issued entry sees the new contents.
- rst mid-run: state returns to IDLE, outputs zero next cycle, no done pulse.
- Counters never wrap past iter_count-1. An iter_count of all ones is legal.

Decomposition:
- Shared package lsu_pkg holds:
  - INST_W, the NOP constant (18'h0)
  - the lane packing offsets for cfg_data
  - the state enum {IDLE, RUN}
- One natural sub-module: lsu_ctx_mem, a CTX_DEPTH x 4*INST_W register file with one write port and one combinational read port.
- Control FSM, counters and output registers live in lsu_inst_sequencer.

Test Plan:
- Reset check: assert rst for 2 cycles with random inputs -> all outputs 0, inst_valid=0, done=0; then write ctx[0] and read back via a run.
- Basic run: load ctx[0..2] with lane values 0x00011/0x00022/0x00033/0x00044 (+entry index); last_pc=2, iter=2, start -> entries 0,1,2,0,1,2 on consecutive cycles from cycle after start; cur_iter 0,0,0,1,1,1; done=1 on 7th cycle; busy low same cycle.
- Stall: same setup, stall high 2 cycles while cur_pc=1 of iteration 0 -> entry 1 held 3 cycles; total 8 valid cycles; done on 9th. Stall on final entry for 3 cycles -> entry 2 held, then single done pulse.
- Zero iterations: iter_count=0, start -> done=1 exactly one cycle after start; inst_valid never asserts; busy stays 0.
- Ignored inputs: during RUN pulse start and cfg_we to ctx[1]=0x3FFFF per lane -> run sequence unchanged; a subsequent run shows the old ctx[1].
- Mid-run reset: rst at cur_pc=1 -> next cycle outputs 0, no done. Restart with last_pc=0, iter=3 -> ctx[0] issued 3 cycles, memory contents intact.
